// File: rtl/xbus_arbiter_if.sv
// Signal bundle shared by the xbus arbiter, its two requesting masters and the slave bus.
// The arbiter uses the master modport (it owns the slave bus); the environment uses slave.
interface xbus_arbiter_if;
  logic        m0_req;
  logic        m0_write;
  logic [21:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m0_nxm;

  logic        m1_req;
  logic        m1_write;
  logic [21:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        m1_nxm;

  logic        bus_req;
  logic        bus_write;
  logic [21:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_decode;
  logic        bus_ack;
  logic        bus_timeout;
  logic        grant;

  modport master (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    input  bus_rdata, bus_decode, bus_ack,
    output m0_rdata, m0_ack, m0_nxm,
    output m1_rdata, m1_ack, m1_nxm,
    output bus_req, bus_write, bus_addr, bus_wdata, bus_timeout, grant
  );

  modport slave (
    output m0_req, m0_write, m0_addr, m0_wdata,
    output m1_req, m1_write, m1_addr, m1_wdata,
    output bus_rdata, bus_decode, bus_ack,
    input  m0_rdata, m0_ack, m0_nxm,
    input  m1_rdata, m1_ack, m1_nxm,
    input  bus_req, bus_write, bus_addr, bus_wdata, bus_timeout, grant
  );
endinterface

// File: rtl/xbus_arbiter.sv
// Two-master xbus arbiter and transaction sequencer with decode/ack timeout (NXM) handling.
// Define XBUS_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority over m1.
module xbus_arbiter #(
  parameter int DECODE_WAIT = 4,
  parameter int ACK_WAIT    = 255,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            reset,
  xbus_arbiter_if.master xb
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, TMO} state_e;

  localparam logic [CNT_W-1:0] DecodeLimit = CNT_W'(DECODE_WAIT - 1);
  localparam logic [CNT_W-1:0] AckLimit    = CNT_W'(ACK_WAIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decoded_q, decoded_d;
  logic             grant_q, grant_d;
  logic             write_q, write_d;
  logic [21:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;
  logic             winner;
  logic             limit_hit;

`ifdef XBUS_ARB_RR_EN
  logic last_q, last_d;

  assign winner = (xb.m0_req && xb.m1_req) ? ~last_q : xb.m1_req;
  assign last_d = (state_q == IDLE && (xb.m0_req || xb.m1_req)) ? winner : last_q;

  // Reset owner is m1 so that m0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign winner = ~xb.m0_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      decoded_q <= 1'b0;
      grant_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decoded_q <= decoded_d;
      grant_q   <= grant_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // The decoded flag selects which deadline applies: decode window in ADDR, ack window in DATA.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decoded_d = decoded_q;
    grant_d   = grant_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    limit_hit = (cnt_q == (decoded_q ? AckLimit : DecodeLimit));

    unique case (state_q)
      IDLE: begin
        if (xb.m0_req || xb.m1_req) begin
          grant_d   = winner;
          write_d   = winner ? xb.m1_write : xb.m0_write;
          addr_d    = winner ? xb.m1_addr  : xb.m0_addr;
          wdata_d   = winner ? xb.m1_wdata : xb.m0_wdata;
          cnt_d     = '0;
          decoded_d = 1'b0;
          state_d   = ADDR;
        end
      end
      ADDR, DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (xb.bus_ack) begin
          if (grant_q) rdata1_d = write_q ? '0 : xb.bus_rdata;
          else         rdata0_d = write_q ? '0 : xb.bus_rdata;
          state_d = DONE;
        end else if (state_q == ADDR && xb.bus_decode) begin
          decoded_d = 1'b1;
          state_d   = DATA;
        end else if (limit_hit) begin
          if (grant_q) rdata1_d = '0;
          else         rdata0_d = '0;
          state_d = TMO;
        end
      end
      DONE, TMO: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign xb.bus_req     = (state_q == ADDR) || (state_q == DATA);
  assign xb.bus_timeout = (state_q == TMO);
  assign xb.bus_write   = write_q;
  assign xb.bus_addr    = addr_q;
  assign xb.bus_wdata   = wdata_q;
  assign xb.grant       = grant_q;

  assign xb.m0_ack   = ((state_q == DONE) || (state_q == TMO)) && !grant_q;
  assign xb.m0_nxm   = (state_q == TMO) && !grant_q;
  assign xb.m0_rdata = rdata0_q;
  assign xb.m1_ack   = ((state_q == DONE) || (state_q == TMO)) && grant_q;
  assign xb.m1_nxm   = (state_q == TMO) && grant_q;
  assign xb.m1_rdata = rdata1_q;

endmodule
